// File: rtl/fwft_fifo_pkg.sv
// Shared constants and helpers for the first-word-fall-through FIFO.
// Defines the skid depth and the width of the total-occupancy counter.
package fwft_fifo_pkg;

  localparam int SKID_DEPTH = 2;

  // Occupancy spans RAM depth plus the in-flight word and the skid entries.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: synchronous write port and registered read port.
// Contents are never cleared; only the read register resets.
module dual_port_ram
  import fwft_fifo_pkg::*;
#(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 5,
  parameter string INIT_FILE  = ""
) (
  input  logic                  wr_clk_i,
  input  logic                  rd_clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int  DEPTH    = 2 ** ADDR_WIDTH;
  localparam bit  HAS_INIT = (INIT_FILE != "");

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  unused_init;

  // Preloading is not supported in this implementation; the name is kept for drop-in compatibility.
  assign unused_init = HAS_INIT;

  always_ff @(posedge wr_clk_i) begin
    if (wr_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge rd_clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fwft_fifo.sv
// First-word-fall-through FIFO: RAM storage with prefetch into a 2-entry skid.
// Write-to-valid latency 3 cycles; sustains one pop per cycle under rd_ready_i.
module fwft_fifo
  import fwft_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int AFULL_LEVEL = 28
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               wr_i,
  input  logic [DATA_WIDTH-1:0]              wr_data_i,
  output logic                               full_o,
  output logic                               almost_full_o,
  output logic                               wr_drop_o,
  output logic [DATA_WIDTH-1:0]              rd_data_o,
  output logic                               rd_valid_o,
  input  logic                               rd_ready_i,
  output logic [cnt_width(ADDR_WIDTH)-1:0]   used_words_o
);

  localparam int                DEPTH     = 2 ** ADDR_WIDTH;
  localparam int                CW        = cnt_width(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] FULL_CNT  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH + 1)'(AFULL_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            skid_cnt_q, skid_cnt_d;
  logic [DATA_WIDTH-1:0] skid_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] skid_d [SKID_DEPTH];
  logic                  wr_drop_q, wr_drop_d;

  logic                  wr_acc;
  logic                  pop;
  logic                  rd_issue;
  logic [2:0]            occ_after;
  logic [DATA_WIDTH-1:0] ram_rd_dat;

  assign full_o        = (ram_cnt_q == FULL_CNT);
  assign almost_full_o = (ram_cnt_q >= AFULL_CNT);
  assign wr_drop_o     = wr_drop_q;
  assign rd_valid_o    = (skid_cnt_q != 2'd0);
  assign rd_data_o     = skid_q[0];
  assign used_words_o  = CW'(ram_cnt_q) + CW'(inflight_q) + CW'(skid_cnt_q);

  assign wr_acc = wr_i & ~full_o;
  assign pop    = rd_valid_o & rd_ready_i;

  // Skid slots that will be committed after this edge if nothing new is issued.
  assign occ_after = {1'b0, skid_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_issue  = ~rst_i && (ram_cnt_q != '0) && (occ_after < 3'(SKID_DEPTH));

  dual_port_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  ("")
  ) storage (
    .wr_clk_i  (clk_i),
    .rd_clk_i  (clk_i),
    .rst_i     (rst_i),
    .wr_i      (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data_i),
    .rd_i      (rd_issue),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rd_dat)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    inflight_d = rd_issue;
    wr_drop_d  = wr_i & full_o;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end

    case ({wr_acc, rd_issue})
      2'b10:   ram_cnt_d = ram_cnt_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - (ADDR_WIDTH + 1)'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase
  end

  always_comb begin
    skid_d     = skid_q;
    skid_cnt_d = skid_cnt_q;

    case ({inflight_q, pop})
      2'b01: begin
        skid_d[0]  = skid_q[1];
        skid_cnt_d = skid_cnt_q - 2'd1;
      end
      2'b10: begin
        skid_d[skid_cnt_q[0]] = ram_rd_dat;
        skid_cnt_d            = skid_cnt_q + 2'd1;
      end
      2'b11: begin
        // Second entry moves to head and the arriving word queues behind it.
        if (skid_cnt_q == 2'd2) begin
          skid_d[0] = skid_q[1];
          skid_d[1] = ram_rd_dat;
        end else begin
          skid_d[0] = ram_rd_dat;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      skid_cnt_q <= 2'd0;
      skid_q     <= '{default: '0};
      wr_drop_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      skid_cnt_q <= skid_cnt_d;
      skid_q     <= skid_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

endmodule

// File: tb/tb_fwft_fifo.sv
// Directed self-checking bench for fwft_fifo with default parameters (8-bit, depth 32).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_fwft_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic [7:0] wr_data;
  logic       full;
  logic       afull;
  logic       drop;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [6:0] used;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fwft_fifo dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wr_i          (wr),
    .wr_data_i     (wr_data),
    .full_o        (full),
    .almost_full_o (afull),
    .wr_drop_o     (drop),
    .rd_data_o     (rd_data),
    .rd_valid_o    (rd_valid),
    .rd_ready_i    (rd_ready),
    .used_words_o  (used)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
    tick();
    tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
    n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rd_data); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (afull !== 1'b0) begin n_bad++; $display("FAIL reset_afull: got %b want 0", afull); end
    n_cmp++; if (drop !== 1'b0) begin n_bad++; $display("FAIL reset_drop: got %b want 0", drop); end
    n_cmp++; if (used !== 7'd0) begin n_bad++; $display("FAIL reset_used: got %0d want 0", used); end
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    wr = 1'b1; wr_data = 8'hA5;
    tick();
    wr = 1'b0;
    n_cmp++; if (used !== 7'd1 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL single_e0: used %0d valid %b want 1 0", used, rd_valid); end
    tick();
    n_cmp++; if (used !== 7'd1 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL single_e1: used %0d valid %b want 1 0", used, rd_valid); end
    tick();
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin n_bad++; $display("FAIL single_e2: valid %b data %h want 1 a5", rd_valid, rd_data); end
    n_cmp++; if (used !== 7'd1) begin n_bad++; $display("FAIL single_used_e2: got %0d want 1", used); end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    n_cmp++; if (used !== 7'd0 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL single_pop: used %0d valid %b want 0 0", used, rd_valid); end
  endtask

  task automatic test_fill_and_drop();
    int exp_ram;
    rd_ready = 1'b0;
    for (int k = 0; k < 34; k++) begin
      wr = 1'b1; wr_data = 8'(k);
      tick();
      exp_ram = (k < 2) ? 1 : k - 1;
      n_cmp++; if (full !== (exp_ram == 32)) begin n_bad++; $display("FAIL fill_full[%0d]: got %b want %b", k, full, exp_ram == 32); end
      n_cmp++; if (afull !== (exp_ram >= 28)) begin n_bad++; $display("FAIL fill_afull[%0d]: got %b want %b", k, afull, exp_ram >= 28); end
      n_cmp++; if (used !== 7'(k + 1)) begin n_bad++; $display("FAIL fill_used[%0d]: got %0d want %0d", k, used, k + 1); end
    end
    wr = 1'b0;
    tick();
    n_cmp++; if (full !== 1'b1 || used !== 7'd34) begin n_bad++; $display("FAIL fill_settled: full %b used %0d want 1 34", full, used); end
    n_cmp++; if (drop !== 1'b0) begin n_bad++; $display("FAIL fill_no_drop: got %b want 0", drop); end
    wr = 1'b1; wr_data = 8'hFF;
    tick();
    wr = 1'b0;
    n_cmp++; if (drop !== 1'b1) begin n_bad++; $display("FAIL drop_pulse: got %b want 1", drop); end
    n_cmp++; if (used !== 7'd34) begin n_bad++; $display("FAIL drop_used: got %0d want 34", used); end
    tick();
    n_cmp++; if (drop !== 1'b0) begin n_bad++; $display("FAIL drop_clear: got %b want 0", drop); end
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin n_bad++; $display("FAIL fill_head: valid %b data %h want 1 00", rd_valid, rd_data); end
  endtask

  task automatic test_drain();
    rd_ready = 1'b1;
    for (int i = 0; i < 34; i++) begin
      n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin n_bad++; $display("FAIL drain[%0d]: valid %b data %h want 1 %h", i, rd_valid, rd_data, 8'(i)); end
      tick();
    end
    rd_ready = 1'b0;
    n_cmp++; if (rd_valid !== 1'b0 || used !== 7'd0) begin n_bad++; $display("FAIL drain_empty: valid %b used %0d want 0 0", rd_valid, used); end
  endtask

  task automatic test_full_with_issue();
    rd_ready = 1'b1; wr = 1'b1; wr_data = 8'hEE;
    tick();
    wr = 1'b0; rd_ready = 1'b0;
    n_cmp++; if (drop !== 1'b1) begin n_bad++; $display("FAIL fullrd_drop: got %b want 1", drop); end
    n_cmp++; if (full !== 1'b0 || afull !== 1'b1) begin n_bad++; $display("FAIL fullrd_flags: full %b afull %b want 0 1", full, afull); end
    n_cmp++; if (used !== 7'd33) begin n_bad++; $display("FAIL fullrd_used: got %0d want 33", used); end
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h01) begin n_bad++; $display("FAIL fullrd_head: valid %b data %h want 1 01", rd_valid, rd_data); end
  endtask

  task automatic test_random_stream();
    logic [7:0] q[$];
    logic [7:0] exp;
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    while (recv < 100 && cyc < 3000) begin
      wr = (sent < 100) && !full;
      wr_data = 8'(sent * 7 + 3);
      rd_ready = 1'($urandom_range(0, 1));
      if (wr) begin
        q.push_back(wr_data);
        sent++;
      end
      if (rd_valid && rd_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL stream_spurious: data %h with nothing outstanding", rd_data);
        end else begin
          exp = q.pop_front();
          if (rd_data !== exp) begin n_bad++; $display("FAIL stream_data[%0d]: got %h want %h", recv, rd_data, exp); end
        end
        recv++;
      end
      tick();
      cyc++;
      n_cmp++; if (drop !== 1'b0) begin n_bad++; $display("FAIL stream_drop: got %b want 0 at cycle %0d", drop, cyc); end
      n_cmp++; if (used > 7'd34) begin n_bad++; $display("FAIL stream_used: got %0d want <=34", used); end
    end
    wr = 1'b0; rd_ready = 1'b0;
    n_cmp++; if (recv != 100) begin n_bad++; $display("FAIL stream_timeout: received %0d want 100", recv); end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 11; k++) begin
      wr = 1'b1; wr_data = 8'(8'h10 + k);
      tick();
    end
    wr = 1'b0;
    tick();
    tick();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    n_cmp++; if (used !== 7'd10) begin n_bad++; $display("FAIL mid_pre_used: got %0d want 10", used); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin n_bad++; $display("FAIL mid_rst_rd: valid %b data %h want 0 00", rd_valid, rd_data); end
    n_cmp++; if (used !== 7'd0 || full !== 1'b0 || afull !== 1'b0 || drop !== 1'b0) begin n_bad++; $display("FAIL mid_rst_flags: used %0d full %b afull %b drop %b want 0", used, full, afull, drop); end
    wr = 1'b1; wr_data = 8'h3C;
    tick();
    wr = 1'b0;
    tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stale: valid %b data %h want 0", rd_valid, rd_data); end
    tick();
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C || used !== 7'd1) begin n_bad++; $display("FAIL mid_after: valid %b data %h used %0d want 1 3c 1", rd_valid, rd_data, used); end
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
    test_reset();
    test_single_word();
    test_fill_and_drop();
    test_drain();
    test_fill_and_drop();
    test_full_with_issue();
    test_reset();
    test_random_stream();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
